// File: rtl/apb_spi_pkg.sv
// Shared register map, status bit positions and field masks for the APB SPI register block.
package apb_spi_pkg;

    typedef enum logic [2:0] {
        REG_CR1 = 3'd0,
        REG_CR2 = 3'd1,
        REG_BR  = 3'd2,
        REG_SR  = 3'd3,
        REG_DR  = 3'd4,
        REG_IER = 3'd5,
        REG_LVL = 3'd6,
        REG_RSV = 3'd7
    } reg_idx_e;

    localparam int SR_RX_NE    = 7;
    localparam int SR_RXOVF    = 6;
    localparam int SR_TX_NF    = 5;
    localparam int SR_TX_EMPTY = 4;
    localparam int SR_TIP      = 3;

    localparam int CR1_SPE     = 6;
    localparam int CR1_MSTR    = 4;
    localparam int CR1_CPOL    = 3;
    localparam int CR1_CPHA    = 2;
    localparam int CR1_LSBFE   = 0;
    localparam int CR2_SPISWAI = 1;

    localparam logic [7:0] CR1_RESET = 8'h04;
    localparam logic [7:0] CR2_MASK  = 8'h1B;
    localparam logic [7:0] BR_MASK   = 8'h77;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; used for both SPI TX and RX.
module spi_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/apb_spi_fifo_slave.sv
// APB register front end for the SPI core with TX/RX FIFOs, status and level registers.
// Define SPI_REGIF_IRQ_EN to implement IER and the registered spi_irq output.
module apb_spi_fifo_slave
    import apb_spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 3
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              tip,
    output logic              spe,
    output logic              mstr,
    output logic              cpol,
    output logic              cpha,
    output logic              lsbfe,
    output logic              spiswai,
    output logic [2:0]        sppr,
    output logic [2:0]        spr,
    output logic              spi_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reg_idx_e          idx;
    logic              idx_ok;
    logic              access;
    logic              err;
    logic              wr_ok;
    logic              rd_ok;
    logic [7:0]        cr1;
    logic [7:0]        cr2;
    logic [7:0]        br;
    logic              rxovf;
    logic [7:0]        sr;
    logic [DATA_W-1:0] lvl;

    logic              flush;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [CW-1:0]     tx_count;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [CW-1:0]     rx_count;
    logic [DATA_W-1:0] rx_head;

    assign idx = reg_idx_e'(PADDR[2:0]);

    generate
        if (ADDR_W > 3) begin : g_wide_addr
            assign idx_ok = ~|PADDR[ADDR_W-1:3];
        end else begin : g_narrow_addr
            assign idx_ok = 1'b1;
        end
    endgenerate

    assign access  = PSEL & PENABLE;
    assign PREADY  = access;
    assign PSLVERR = access & err;
    assign wr_ok   = access & PWRITE & ~err;
    assign rd_ok   = access & ~PWRITE & ~err;

    always_comb begin
        err = 1'b0;
        if (!idx_ok) begin
            err = 1'b1;
        end else if (PWRITE) begin
            case (idx)
                REG_CR1, REG_CR2, REG_BR: err = tip;
                REG_DR:                   err = tx_full;
                REG_LVL, REG_RSV:         err = 1'b1;
                default:                  err = 1'b0;
            endcase
        end else begin
            case (idx)
                REG_DR:  err = rx_empty;
                REG_RSV: err = 1'b1;
                default: err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cr1 <= CR1_RESET;
            cr2 <= '0;
            br  <= '0;
        end else if (wr_ok) begin
            case (idx)
                REG_CR1: cr1 <= PWDATA[7:0];
                REG_CR2: cr2 <= PWDATA[7:0] & CR2_MASK;
                REG_BR:  br  <= PWDATA[7:0] & BR_MASK;
                default: ;
            endcase
        end
    end

    // Disabling the core discards everything queued in either direction.
    assign flush   = wr_ok & (idx == REG_CR1) & ~PWDATA[CR1_SPE];
    assign tx_push = wr_ok & (idx == REG_DR);
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_pop  = rd_ok & (idx == REG_DR);
    assign rx_push = rx_valid & (~rx_full | rx_pop);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rxovf <= 1'b0;
        end else if (flush) begin
            rxovf <= 1'b0;
        end else if (rx_valid && rx_full && !rx_pop) begin
            rxovf <= 1'b1;
        end else if (wr_ok && (idx == REG_SR) && PWDATA[SR_RXOVF]) begin
            rxovf <= 1'b0;
        end
    end

    spi_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .flush  (flush),
        .push   (tx_push),
        .pop    (tx_pop),
        .wdata  (PWDATA),
        .rdata  (tx_data),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    spi_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .flush  (flush),
        .push   (rx_push),
        .pop    (rx_pop),
        .wdata  (rx_data),
        .rdata  (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

    assign tx_valid = spe & ~tx_empty;

    assign sr  = {~rx_empty, rxovf, ~tx_full, tx_empty, tip, 3'b000};
    assign lvl = DATA_W'({rx_count, tx_count});

    assign spe     = cr1[CR1_SPE];
    assign mstr    = cr1[CR1_MSTR];
    assign cpol    = cr1[CR1_CPOL];
    assign cpha    = cr1[CR1_CPHA];
    assign lsbfe   = cr1[CR1_LSBFE];
    assign spiswai = cr2[CR2_SPISWAI];
    assign sppr    = br[6:4];
    assign spr     = br[2:0];

`ifdef SPI_REGIF_IRQ_EN
    // Only SR[7:4] can raise an interrupt, so only those enable bits are stored.
    logic [3:0] ier_hi;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ier_hi  <= '0;
            spi_irq <= 1'b0;
        end else begin
            if (wr_ok && (idx == REG_IER)) ier_hi <= PWDATA[7:4];
            spi_irq <= |(sr[7:4] & ier_hi);
        end
    end
`else
    assign spi_irq = 1'b0;
`endif

    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE && idx_ok) begin
            case (idx)
                REG_CR1: PRDATA = DATA_W'(cr1);
                REG_CR2: PRDATA = DATA_W'(cr2);
                REG_BR:  PRDATA = DATA_W'(br);
                REG_SR:  PRDATA = DATA_W'(sr);
                REG_DR:  PRDATA = rx_empty ? '0 : rx_head;
`ifdef SPI_REGIF_IRQ_EN
                REG_IER: PRDATA = DATA_W'({ier_hi, 4'b0000});
`endif
                REG_LVL: PRDATA = lvl;
                default: PRDATA = '0;
            endcase
        end
    end

endmodule

// File: doc/apb_spi_fifo_slave.md
# apb_spi_fifo_slave

APB register interface for the SPI core: a parametrised successor of the single-register SPI slave interface. Transmit and receive traffic is buffered in independent FIFOs, and the block adds configurable data width, a level/error status register and maskable interrupts. It sits between the APB bus and the SPI shift/baud logic, driving configuration fields and a valid/ready byte stream to the shifter.

## Interface
- DATA_W, 8, SPI frame and PWDATA/PRDATA width (8 or 16); control registers occupy bits [7:0], upper bits read 0
- FIFO_DEPTH, 4, entries per TX and RX FIFO; power of two, >= 2
- ADDR_W, 3, PADDR width
- PCLK  in  1  sole clock
- PRESET  in  1  asynchronous, active-high reset (one clock; reset asynchronous and active-high)
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  ADDR_W  register word index
- PWDATA  in  DATA_W  write data
- PRDATA  out  DATA_W  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- tx_data  out  DATA_W  TX FIFO head
- tx_valid  out  1  head valid
- tx_ready  in  1  shifter accepts head
- rx_data  in  DATA_W  received frame
- rx_valid  in  1  one-cycle push strobe
- tip  in  1  transfer in progress
- spe, mstr, cpol, cpha, lsbfe, spiswai  out  1  CR1/CR2 fields
- sppr, spr  out  3  baud dividers
- spi_irq  out  1  interrupt request, registered

## Operation
- Register map: 0 CR1, 1 CR2 (mask 0x1B), 2 BR (mask 0x77), 3 SR, 4 DR, 5 IER, 6 LVL (RO: {rx_count, tx_count}, each $clog2(FIFO_DEPTH)+1 bits, packed from bit 0), 7 reserved.
- Access phase = PSEL & PENABLE. PREADY = access phase; zero wait states.
- Write effects commit on the access-phase clock edge.
- DR write pushes the TX FIFO. DR read returns the RX head and pops it.
- PSLVERR = 1 in the access phase for any of:
  - DR write while TX is full (full flag registered; a same-cycle pop does not rescue it)
  - DR read while RX is empty (PRDATA = 0)
  - CR1/CR2/BR write while tip = 1
  - write to LVL or address 7
  - read of address 7
- An erroring access has no side effect.
- SR bits:
  - [7] rx_ne
  - [6] rxovf, sticky; cleared by writing 1 to SR[6]; SR writes are otherwise ignored and are not errors
  - [5] tx_nf
  - [4] tx_empty
  - [3] tip
  - others 0
- tx_valid = spe & !tx_empty. A pop occurs on tx_valid & tx_ready.
- An rx_valid push while RX is full drops the data and sets rxovf.
  - Exception: if an APB DR read pops in the same cycle, both complete and no overflow occurs.
- CR1 write with spe = 0 flushes both FIFOs and clears rxovf on that edge.
- Pointers wrap modulo FIFO_DEPTH. Counts saturate at 0 and FIFO_DEPTH by construction.
- Reset values:
  - CR1 = 0x04; CR2, BR, IER = 0
  - FIFOs empty, rxovf = 0
  - PRDATA = 0, PSLVERR = 0, spi_irq = 0, tx_valid = 0
  - SR reads 0x30
- Reset asserted mid-transfer aborts it; FIFO contents are lost.

## Timing
- PRDATA is combinational from registers/FIFO head during a read access phase, and 0 otherwise.
- Flags, counts and config outputs update on the edge after the causing event.
- spi_irq follows a flag by one further cycle (registered from SR & IER).
- tx_data is combinational from storage at the read pointer; stable while tx_valid & !tx_ready.
- Back-to-back APB accesses (SETUP immediately after ACCESS) are supported.

## Configuration
- SPI_REGIF_IRQ_EN defined: IER is implemented, and spi_irq = |(SR[7:4] & IER[7:4]), registered.
- SPI_REGIF_IRQ_EN undefined:
  - IER reads 0 and writes are ignored (no error)
  - spi_irq is tied to 0
  - no interrupt flops are synthesised

## Structure
- Package apb_spi_pkg holds:
  - register index constants
  - SR bit positions
  - CR2/BR masks (0x1B, 0x77)
  - CR1 reset value
- One sub-module, spi_sync_fifo (DATA_W, FIFO_DEPTH), instantiated twice for TX and RX. It provides push/pop, full/empty, count and flush.

## Test plan
- Reset, then read SR, CR1, LVL: 0x30, 0x04, 0x00. spi_irq = 0.
- spe = 1, tx_ready = 0, write DR 0x11..0x14: LVL tx = 4. A fifth write gives PSLVERR = 1 and LVL is unchanged. Raise tx_ready: 0x11..0x14 emerge in order and tx_empty sets.
- Push 5 rx_valid frames with DEPTH = 4: SR[6] = 1. Reads return the first 4 frames. A fifth read gives PSLVERR = 1 and PRDATA = 0. Writing SR = 0x40 clears rxovf.
- RX full, rx_valid coincident with a DR read: no rxovf, and rx_count stays 4.
- tip = 1, write BR 0xFF: PSLVERR = 1 and BR is unchanged. With tip = 0 the same write reads back 0x77.
- IER = 0x80 (IRQ_EN build), then one rx_valid: spi_irq rises 2 cycles later and falls 2 cycles after the DR read empties RX.
